fifo_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one UART TX serializer between two async FIFOs, source 0 and source 1. It sits in the FIFO read-clock domain (the UART TX clock). It pops one word at a time from a non-empty FIFO, presents it to the UART TX with a valid/busy handshake, and waits for the frame to finish before granting again.

---
 rtl/fifo_arb_pkg.sv | 17 +
 rtl/fifo_tx_arbiter_if.sv | 30 +++
 rtl/rr_arb2.sv | 19 +
 rtl/fifo_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_fifo_tx_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO-to-UART round-robin arbiter: FSM state encoding and default sizes.
// The optional burst mode is selected with the FIFO_ARB_BURST_EN macro.
package fifo_arb_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        POP     = 3'd1,
        SEND    = 3'd2,
        WAIT_HI = 3'd3,
        WAIT_LO = 3'd4
    } arb_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_BUSY_WAIT  = 15;
    localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/fifo_tx_arbiter_if.sv
// Bundle of the two FIFO read ports and the UART TX handshake.
// The master modport is the arbiter side; the slave modport is the FIFO/UART side.
interface fifo_tx_arbiter_if
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  EMPTY0;
    logic [DATA_WIDTH-1:0] RD_DATA0;
    logic                  R_INC0;
    logic                  EMPTY1;
    logic [DATA_WIDTH-1:0] RD_DATA1;
    logic                  R_INC1;
    logic                  TX_BUSY;
    logic [DATA_WIDTH-1:0] TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  GRANT;
    logic                  ARB_ACTIVE;

    modport master (
        input  EMPTY0, RD_DATA0, EMPTY1, RD_DATA1, TX_BUSY,
        output R_INC0, R_INC1, TX_P_DATA, TX_D_VLD, GRANT, ARB_ACTIVE
    );

    modport slave (
        output EMPTY0, RD_DATA0, EMPTY1, RD_DATA1, TX_BUSY,
        input  R_INC0, R_INC1, TX_P_DATA, TX_D_VLD, GRANT, ARB_ACTIVE
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker: on a tie the source that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       pick,
    output logic       any
);

    always_comb begin
        any  = |req;
        pick = 1'b0;
        if (&req) begin
            pick = ~last;
        end else begin
            pick = req[1];
        end
    end

endmodule

// File: rtl/fifo_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX between two FIFOs, one word per grant.
// Define FIFO_ARB_BURST_EN to let one source send up to MAX_BURST words back to back.
module fifo_tx_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BUSY_WAIT  = DEF_BUSY_WAIT
`ifdef FIFO_ARB_BURST_EN
    ,
    parameter int MAX_BURST  = DEF_MAX_BURST
`endif
) (
    input logic               CLK,
    input logic               RST,
    fifo_tx_arbiter_if.master bus
);

    localparam int TW = $clog2(BUSY_WAIT + 1);

    arb_state_t            state, state_d;
    logic                  grant_q, grant_d;
    logic                  last_q, last_d;
    logic                  pick, req_any;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [TW-1:0]         tmo_q, tmo_d;

`ifdef FIFO_ARB_BURST_EN
    localparam int BCW = $clog2(MAX_BURST + 1);
    logic [BCW-1:0] burst_q, burst_d;
    logic           head_ready;
    assign head_ready = grant_q ? ~bus.EMPTY1 : ~bus.EMPTY0;
`endif

    rr_arb2 u_rr (
        .req  ({~bus.EMPTY1, ~bus.EMPTY0}),
        .last (last_q),
        .pick (pick),
        .any  (req_any)
    );

    // last_q resets to 1 so that source 0 wins the first tie
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
            tmo_q   <= '0;
`ifdef FIFO_ARB_BURST_EN
            burst_q <= '0;
`endif
        end else begin
            state   <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
`ifdef FIFO_ARB_BURST_EN
            burst_q <= burst_d;
`endif
        end
    end

    always_comb begin
        state_d        = state;
        grant_d        = grant_q;
        last_d         = last_q;
        data_d         = data_q;
        tmo_d          = tmo_q;
`ifdef FIFO_ARB_BURST_EN
        burst_d        = burst_q;
`endif
        bus.R_INC0     = (state == POP) && !grant_q;
        bus.R_INC1     = (state == POP) && grant_q;
        bus.TX_D_VLD   = (state == SEND);
        bus.TX_P_DATA  = data_q;
        bus.GRANT      = grant_q;
        bus.ARB_ACTIVE = (state != IDLE);

        case (state)
            IDLE: begin
                if (req_any && !bus.TX_BUSY) begin
                    grant_d = pick;
                    state_d = POP;
`ifdef FIFO_ARB_BURST_EN
                    burst_d = '0;
`endif
                end
            end
            POP: begin
                data_d  = grant_q ? bus.RD_DATA1 : bus.RD_DATA0;
                state_d = SEND;
            end
            SEND: begin
                tmo_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.TX_BUSY) begin
                    state_d = WAIT_LO;
                end else begin
                    if (tmo_q != TW'(BUSY_WAIT)) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                    // UART never acknowledged: the word is abandoned
                    if (tmo_q >= TW'(BUSY_WAIT - 1)) begin
                        state_d = IDLE;
`ifdef FIFO_ARB_BURST_EN
                        burst_d = '0;
`endif
                    end
                end
            end
            WAIT_LO: begin
                if (!bus.TX_BUSY) begin
                    last_d  = grant_q;
                    state_d = IDLE;
`ifdef FIFO_ARB_BURST_EN
                    if (head_ready && (burst_q < BCW'(MAX_BURST - 1))) begin
                        burst_d = burst_q + BCW'(1);
                        state_d = POP;
                    end else begin
                        burst_d = '0;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_tx_arbiter.sv
// Self-checking bench for fifo_tx_arbiter: FIFO and UART models, a cycle-level reference model,
// and directed scenarios. Build with FIFO_ARB_BURST_EN defined to exercise burst mode.
module tb_fifo_tx_arbiter;

    localparam int DW        = 8;
    localparam int BUSY_WAIT = 15;
    localparam int FRAME_LEN = 10;
`ifdef FIFO_ARB_BURST_EN
    localparam int MAX_BURST = 4;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b0;
    always #5 CLK = ~CLK;

    fifo_tx_arbiter_if #(.DATA_WIDTH(DW)) bus ();

    fifo_tx_arbiter #(.DATA_WIDTH(DW), .BUSY_WAIT(BUSY_WAIT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW-1:0] tx_log[$];
    bit            uart_on    = 1'b1;
    bit            force_busy = 1'b0;
    int            uart_cnt   = 0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO and UART environment: pops and busy updates land just after the clock edge
    initial begin
        bus.EMPTY0 = 1'b1; bus.EMPTY1 = 1'b1;
        bus.RD_DATA0 = '0; bus.RD_DATA1 = '0; bus.TX_BUSY = 1'b0;
        forever begin
            logic p0, p1, v;
            @(posedge CLK);
            p0 = bus.R_INC0; p1 = bus.R_INC1; v = bus.TX_D_VLD;
            #1;
            if (p0 && q0.size() != 0) void'(q0.pop_front());
            if (p1 && q1.size() != 0) void'(q1.pop_front());
            if (uart_cnt > 0) uart_cnt--;
            if (v && uart_on) uart_cnt = FRAME_LEN;
            bus.TX_BUSY  = force_busy || (uart_cnt > 0);
            bus.EMPTY0   = (q0.size() == 0);
            bus.EMPTY1   = (q1.size() == 0);
            bus.RD_DATA0 = (q0.size() != 0) ? q0[0] : '0;
            bus.RD_DATA1 = (q1.size() != 0) ? q1[0] : '0;
        end
    end

    // Reference model: m_age counts cycles since a grant decision (0 = idle)
    int            m_age = 0, m_waited = 0, m_run = 0;
    bit            m_seen = 1'b0;
    logic          m_grant = 1'b0, m_last = 1'b1;
    logic [DW-1:0] m_word = '0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_age <= 0; m_waited <= 0; m_run <= 0; m_seen <= 1'b0;
            m_grant <= 1'b0; m_last <= 1'b1; m_word <= '0;
        end else begin
            if (m_age == 0) begin
                if (!bus.TX_BUSY && (!bus.EMPTY0 || !bus.EMPTY1)) begin
                    m_grant <= (!bus.EMPTY0 && !bus.EMPTY1) ? ~m_last : bus.EMPTY0;
                    m_age   <= 1;
                    m_run   <= 1;
                end
            end else if (m_age == 1) begin
                m_word <= m_grant ? bus.RD_DATA1 : bus.RD_DATA0;
                m_age  <= 2;
            end else if (m_age == 2) begin
                m_age <= 3; m_waited <= 0; m_seen <= 1'b0;
            end else if (!m_seen) begin
                if (bus.TX_BUSY) m_seen <= 1'b1;
                else begin
                    m_waited <= m_waited + 1;
                    if (m_waited + 1 == BUSY_WAIT) m_age <= 0;
                end
            end else if (!bus.TX_BUSY) begin
                m_last <= m_grant;
                m_age  <= 0;
`ifdef FIFO_ARB_BURST_EN
                if ((m_grant ? !bus.EMPTY1 : !bus.EMPTY0) && m_run < MAX_BURST) begin
                    m_age <= 1;
                    m_run <= m_run + 1;
                end
`endif
            end
        end
    end

    always @(negedge CLK) begin
        if (RST) begin
            check_output("r_inc0",     bus.R_INC0,     (m_age == 1) && !m_grant);
            check_output("r_inc1",     bus.R_INC1,     (m_age == 1) && m_grant);
            check_output("tx_d_vld",   bus.TX_D_VLD,   m_age == 2);
            check_output("grant",      bus.GRANT,      m_grant);
            check_output("tx_p_data",  bus.TX_P_DATA,  m_word);
            check_output("arb_active", bus.ARB_ACTIVE, m_age != 0);
            check_output("r_inc_excl", bus.R_INC0 & bus.R_INC1, 1'b0);
            check_output("pop_empty0", bus.R_INC0 & bus.EMPTY0, 1'b0);
            check_output("pop_empty1", bus.R_INC1 & bus.EMPTY1, 1'b0);
            if (bus.TX_D_VLD) tx_log.push_back(bus.TX_P_DATA);
        end
    end

    task automatic check_all_zero(input string tag);
        check_output({tag, "_r_inc0"},  bus.R_INC0,     1'b0);
        check_output({tag, "_r_inc1"},  bus.R_INC1,     1'b0);
        check_output({tag, "_vld"},     bus.TX_D_VLD,   1'b0);
        check_output({tag, "_grant"},   bus.GRANT,      1'b0);
        check_output({tag, "_active"},  bus.ARB_ACTIVE, 1'b0);
        check_output({tag, "_data"},    bus.TX_P_DATA,  8'h00);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST = 1'b0;
        q0.delete(); q1.delete(); tx_log.delete();
        #1 check_all_zero("reset");
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (!bus.ARB_ACTIVE && !bus.TX_BUSY && q0.size() == 0 && q1.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check_output({name, "_drain"}, done, 1'b1);
    endtask

    task automatic wait_vld(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (bus.TX_D_VLD) begin
                done = 1'b1;
                break;
            end
        end
        check_output({name, "_vld_seen"}, done, 1'b1);
    endtask

    task automatic check_log(input string name, input logic [DW-1:0] exp[$]);
        check_output({name, "_count"}, tx_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < tx_log.size(); i++)
            check_output($sformatf("%s_word%0d", name, i), tx_log[i], exp[i]);
    endtask

    task automatic apply_stimulus();
        logic [DW-1:0] exp[$];
        int            cnt;
        bit            hit;

        $display("[TB] scenario 1: single word latency");
        apply_reset();
        @(negedge CLK); q0.push_back(8'hA5);
        @(posedge CLK); #2;
        @(negedge CLK); check_output("t1_r_inc0_c0", bus.R_INC0, 1'b0);
        @(negedge CLK); check_output("t1_r_inc0_c1", bus.R_INC0, 1'b1);
        @(negedge CLK); check_output("t1_vld_c2",    bus.TX_D_VLD, 1'b1);
        check_output("t1_data", bus.TX_P_DATA, 8'hA5);
        check_output("t1_grant", bus.GRANT, 1'b0);
        wait_idle("t1");
        check_output("t1_data_held", bus.TX_P_DATA, 8'hA5);

        $display("[TB] scenario 2: alternating sources");
        apply_reset();
        @(negedge CLK);
        q0.push_back(8'h11); q0.push_back(8'h12);
        q1.push_back(8'h22); q1.push_back(8'h23);
        wait_idle("t2");
`ifdef FIFO_ARB_BURST_EN
        exp = '{8'h11, 8'h12, 8'h22, 8'h23};
`else
        exp = '{8'h11, 8'h22, 8'h12, 8'h23};
`endif
        check_log("t2", exp);

        $display("[TB] scenario 3: busy timeout");
        uart_on = 1'b0;
        @(negedge CLK); q0.push_back(8'h5A);
        wait_vld("t3");
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (!bus.ARB_ACTIVE) break;
            cnt++;
        end
        check_output("t3_wait_hi_cycles", cnt, BUSY_WAIT);
        uart_on = 1'b1;
        tx_log.delete();
        @(negedge CLK); q0.push_back(8'h3C);
        wait_idle("t3b");
        exp = '{8'h3C};
        check_log("t3b", exp);

        $display("[TB] scenario 4: request while UART busy");
        @(negedge CLK); force_busy = 1'b1; q1.push_back(8'h77);
        hit = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (bus.R_INC1) hit = 1'b1;
        end
        check_output("t4_no_pop_busy", hit, 1'b0);
        force_busy = 1'b0;
        @(negedge CLK); check_output("t4_r_inc1_early", bus.R_INC1, 1'b0);
        @(negedge CLK); check_output("t4_r_inc1", bus.R_INC1, 1'b1);
        wait_idle("t4");

        $display("[TB] scenario 5: reset in WAIT_LO");
        @(negedge CLK);
        q0.push_back(8'h44); q0.push_back(8'h45); q1.push_back(8'h55);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.ARB_ACTIVE && bus.TX_BUSY) begin
                hit = 1'b1;
                break;
            end
        end
        check_output("t5_reached_busy", hit, 1'b1);
        @(negedge CLK);
        check_output("t5_grant_before", bus.GRANT, 1'b0);
        #2 RST = 1'b0;
        #1 check_all_zero("t5_async");
        @(posedge CLK); #3 RST = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (bus.R_INC0 || bus.R_INC1) begin
                hit = 1'b1;
                break;
            end
        end
        check_output("t5_pop_seen", hit, 1'b1);
        check_output("t5_first_r_inc0", bus.R_INC0, 1'b1);
        check_output("t5_first_grant", bus.GRANT, 1'b0);
        wait_idle("t5");

`ifdef FIFO_ARB_BURST_EN
        $display("[TB] scenario 6: bursts of MAX_BURST");
        apply_reset();
        @(negedge CLK);
        for (int i = 0; i < 5; i++) begin
            q0.push_back(8'hA0 + 8'(i));
            q1.push_back(8'hB0 + 8'(i));
        end
        wait_idle("t6");
        exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hA4, 8'hB4};
        check_log("t6", exp);
`endif
    endtask

    initial begin
        apply_stimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
